lcd_rx_decoder: RTL
===================

Name: lcd_rx_decoder

Overview:
- Receive-side counterpart of the board LCD write path: passively snoops LCDE/LCDRS/LCDRW/LCDDAT as driven toward the HD44780-style 16x2 panel.
- Reassembles 4-bit nibble pairs into bytes and decodes commands.
- Maintains a 32-character shadow of the display. Used on-chip for readback/self-check of the LCD driver, and in benches as the panel model.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on each asynchronous LCD input (min 2).
- NUM_CHARS, 32, shadow buffer size; two lines of 16.
- CLR_CHAR, 8'h20, fill value for clear and reset.

Ports:
- CCLK  in  1  system clock.
- RSTN  in  1  synchronous active-low reset.
- LCDE  in  1  LCD enable strobe; byte nibble captured on its falling edge.
- LCDRS  in  1  register select; 0 = command, 1 = data.
- LCDRW  in  1  read/write; 1 = read.
- LCDDAT  in  4  data nibble, D7..D4.
- rd_addr  in  5  shadow read address.
- rd_char  out  8  shadow[rd_addr], registered, 1-cycle latency.
- byte_valid  out  1  one-cycle pulse when a byte or 8-bit-mode nibble is accepted.
- byte_out  out  8  accepted byte.
- byte_rs  out  1  RS of the accepted byte.
- cursor  out  5  current DDRAM index, 0..31.
- disp_on  out  1  display-control D bit.
- mode4  out  1  4-bit interface active.
- busy  out  1  clear/fill sequence running.
- overrun  out  1  sticky; strobe dropped while busy with the pending slot already full.
- bad_addr  out  1  sticky; set-DDRAM to an unmapped address.

Behaviour:
- Inputs pass through SYNC_STAGES flops. A falling edge is synchronized E 1 then 0. Capture uses the RS/RW/DAT values from the last cycle E was high.
- Strobes with RW=1 are discarded and do not advance the nibble phase.
- FSM states: INIT8, NIB_HI, NIB_LO.
  - INIT8: each strobe is a full command with the low nibble taken as 0. Pulses byte_valid.
    - 0x3x stays in INIT8.
    - 0x2x goes to NIB_HI and sets mode4=1.
  - NIB_HI: latch the high nibble and RS, go to NIB_LO.
  - NIB_LO: form the byte (RS from the high nibble), pulse byte_valid, execute, go to NIB_HI.
- Command decode by leading one:
  - 0x01 clear: fill buffer with CLR_CHAR, 1 entry/cycle, 32 cycles, busy=1. Then cursor=0 and increment mode set.
  - 0x02/0x03 home: cursor=0.
  - 0x04-07 entry mode: record I/D (bit1).
  - 0x08-0F display control: disp_on=bit2.
  - 0x10-1F shift: no effect.
  - 0x20-3F function set: if DL (bit4)=1, mode4=0 and FSM goes to INIT8.
  - 0x40-7F CGRAM address: enter CG mode; data bytes discarded until the next 0x80+ command.
  - 0x80|a: a in 0x00-0x0F maps to cursor=a; a in 0x40-0x4F maps to cursor=16+(a-0x40); any other a sets bad_addr and leaves cursor unchanged.
- Data byte (not CG mode): shadow[cursor]=byte. Cursor then moves +1 (I/D=1) or -1 (I/D=0), modulo 32, so 15 goes to 16 and 31 goes to 0.
- While busy: the first strobe is held in a 1-entry pending slot and executed in the cycle after busy falls. A further strobe sets overrun and is dropped.
- Reset (RSTN=0 at a clock edge, including mid-clear or mid-nibble):
  - FSM=INIT8; mode4=0; cursor=0; I/D=1; disp_on=0.
  - byte_valid=0; byte_out=0; byte_rs=0; rd_char=0.
  - overrun=0; bad_addr=0; pending slot emptied; CG mode off.
  - After RSTN rises, a 32-cycle CLR_CHAR fill runs with busy=1. busy holds 1 during reset.

Optional Feature:
- Macro LCD_RX_STATS_EN. When defined, adds outputs cmd_count[15:0] and data_count[15:0]:
  - cmd_count counts executed commands, including INIT8 nibbles.
  - data_count counts data bytes written to the buffer.
  - Both saturate at 16'hFFFF and are zeroed by reset.
- When not defined, both ports exist and are tied to 0, with no counter logic.

Decomposition:
- Package lcd_rx_pkg: FSM state enum; command masks/codes (CLEAR, HOME, ENTRY, DISPCTL, SHIFT, FUNCSET, CGRAM, DDRAM); line base addresses 0x00/0x40; default CLR_CHAR.
- Sub-module lcd_edge_sync: synchronizer chain plus E falling-edge detect. Outputs a one-cycle strobe and captured rs/rw/dat.

Test Plan:
- Reset release -> busy=1 for exactly 32 cycles; then every rd_addr returns 8'h20; cursor=0; mode4=0.
- Nibbles 3,3,3,2 (RS=0) -> four byte_valid pulses with byte_out 30,30,30,20; mode4=1 after the 4th.
- In 4-bit mode, cmd 0x0C, then 0x80, then data 'H'(48),'i'(69) -> disp_on=1; shadow[0]=48, shadow[1]=69; cursor=2.
- Cmd 0xC0 then data 41; cmd 0x8F then data 42,43 -> shadow[16]=41, shadow[15]=42, shadow[16]=43; cursor=17.
- Entry 0x04, cmd 0x80, data 5A -> shadow[0]=5A, cursor=31. Then cmd 0x90 -> bad_addr=1, cursor stays 31.
- Cmd 0x01, data 58 strobed at clear cycle 5, data 59 at cycle 10 -> 58 written to shadow[0] after busy falls; overrun=1; shadow[1]=20. Asserting RSTN low mid-clear restarts the full 32-cycle fill.

Source files
------------

// File: rtl/lcd_rx_pkg.sv
// lcd_rx_pkg: shared types and constants for the LCD receive-side decoder.
//   - lcd_state_e : nibble-assembly FSM states
//   - CMD_*       : leading-one class codes of HD44780 commands
//   - LINE*_BASE  : DDRAM base addresses of the two display lines
//   - DEF_CLR_CHAR: default fill character (space)
//   - cmd_lead()  : isolates the leading one of a command byte
package lcd_rx_pkg;

   typedef enum logic [1:0] {
      StInit8,
      StNibHi,
      StNibLo
   } lcd_state_e;

   localparam logic [7:0] CMD_CLEAR   = 8'h01;
   localparam logic [7:0] CMD_HOME    = 8'h02;
   localparam logic [7:0] CMD_ENTRY   = 8'h04;
   localparam logic [7:0] CMD_DISPCTL = 8'h08;
   localparam logic [7:0] CMD_SHIFT   = 8'h10;
   localparam logic [7:0] CMD_FUNCSET = 8'h20;
   localparam logic [7:0] CMD_CGRAM   = 8'h40;
   localparam logic [7:0] CMD_DDRAM   = 8'h80;

   localparam logic [6:0] LINE0_BASE = 7'h00;
   localparam logic [6:0] LINE1_BASE = 7'h40;

   localparam logic [7:0] DEF_CLR_CHAR = 8'h20;

   // One-hot of the most significant set bit; 0 for a zero byte.
   function automatic logic [7:0] cmd_lead(input logic [7:0] b);
      logic [7:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) begin
            r    = '0;
            r[i] = 1'b1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/lcd_edge_sync.sv
// lcd_edge_sync: synchronizes the asynchronous LCD bus and detects E falling edges.
//   i_clk, i_rstn        : clock, synchronous active-low reset
//   i_e/i_rs/i_rw/i_dat  : raw LCD bus
//   o_stb                : one-cycle strobe on a synchronized E falling edge
//   o_rs/o_rw/o_dat      : bus values from the last cycle E was high
module lcd_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       i_clk,
   input  logic       i_rstn,
   input  logic       i_e,
   input  logic       i_rs,
   input  logic       i_rw,
   input  logic [3:0] i_dat,
   output logic       o_stb,
   output logic       o_rs,
   output logic       o_rw,
   output logic [3:0] o_dat
);

   localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   logic [6:0] r_sync [STAGES];
   logic [6:0] w_in;
   logic [6:0] w_sy;
   logic       r_e_prev;
   logic [5:0] r_cap;

   assign w_in = {i_e, i_rs, i_rw, i_dat};
   assign w_sy = r_sync[STAGES-1];

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         for (int i = 0; i < STAGES; i++) r_sync[i] <= '0;
         r_e_prev <= 1'b0;
         r_cap    <= '0;
      end else begin
         r_sync[0] <= w_in;
         for (int i = 1; i < STAGES; i++) r_sync[i] <= r_sync[i-1];
         r_e_prev <= w_sy[6];
         // Bus is stable while E is high; keep the last such sample.
         if (w_sy[6]) r_cap <= w_sy[5:0];
      end
   end

   assign o_stb                  = r_e_prev & ~w_sy[6];
   assign {o_rs, o_rw, o_dat}    = r_cap;

endmodule

// File: rtl/lcd_rx_decoder.sv
// lcd_rx_decoder: passive HD44780 bus snooper keeping a 32-character display shadow.
//   CCLK, RSTN            : clock, synchronous active-low reset
//   LCDE/LCDRS/LCDRW/LCDDAT: snooped LCD bus (4-bit nibble D7..D4)
//   rd_addr / rd_char     : shadow read port, 1-cycle latency
//   byte_valid/byte_out/byte_rs : pulse + value of each accepted byte
//   cursor, disp_on, mode4, busy : decoded panel state
//   overrun, bad_addr     : sticky error flags
//   cmd_count, data_count : statistics, real counters only with LCD_RX_STATS_EN defined
module lcd_rx_decoder
   import lcd_rx_pkg::*;
#(
   parameter int          SYNC_STAGES = 2,
   parameter int          NUM_CHARS   = 32,
   parameter logic [7:0]  CLR_CHAR    = DEF_CLR_CHAR
) (
   input  logic        CCLK,
   input  logic        RSTN,
   input  logic        LCDE,
   input  logic        LCDRS,
   input  logic        LCDRW,
   input  logic [3:0]  LCDDAT,
   input  logic [4:0]  rd_addr,
   output logic [7:0]  rd_char,
   output logic        byte_valid,
   output logic [7:0]  byte_out,
   output logic        byte_rs,
   output logic [4:0]  cursor,
   output logic        disp_on,
   output logic        mode4,
   output logic        busy,
   output logic        overrun,
   output logic        bad_addr,
   output logic [15:0] cmd_count,
   output logic [15:0] data_count
);

   localparam logic [4:0] LAST_IDX = 5'(NUM_CHARS - 1);

   logic       w_stb, w_rs, w_rw;
   logic [3:0] w_dat;

   lcd_state_e r_state, w_state_d;
   logic [3:0] r_hi, w_hi_d;
   logic       r_hi_rs, w_hi_rs_d;

   logic       w_new_vld, w_new_rs, w_new_data;
   logic [7:0] w_new_byte;
   logic       w_ex_vld, w_ex_data;
   logic [7:0] w_ex_byte;

   logic       r_byte_valid, w_byte_valid_d;
   logic [7:0] r_byte_out, w_byte_out_d;
   logic       r_byte_rs, w_byte_rs_d;
   logic       r_pend_vld, w_pend_vld_d;
   logic       r_pend_data, w_pend_data_d;
   logic [7:0] r_pend_byte, w_pend_byte_d;
   logic       r_busy, w_busy_d;
   logic [4:0] r_clr_cnt, w_clr_cnt_d;
   logic [4:0] r_cursor, w_cursor_d;
   logic       r_id, w_id_d;
   logic       r_disp_on, w_disp_on_d;
   logic       r_cg, w_cg_d;
   logic       r_overrun, w_overrun_d;
   logic       r_bad_addr, w_bad_addr_d;

   logic       w_mem_we;
   logic [4:0] w_mem_addr;
   logic [7:0] w_mem_wdata;
   logic [7:0] r_mem [NUM_CHARS];
   logic [7:0] r_rd_char;

   lcd_edge_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .i_clk  (CCLK),
      .i_rstn (RSTN),
      .i_e    (LCDE),
      .i_rs   (LCDRS),
      .i_rw   (LCDRW),
      .i_dat  (LCDDAT),
      .o_stb  (w_stb),
      .o_rs   (w_rs),
      .o_rw   (w_rw),
      .o_dat  (w_dat)
   );

   // Nibble assembly. Runs even while busy so a whole byte can wait in the pending slot.
   always_comb begin
      w_state_d  = r_state;
      w_hi_d     = r_hi;
      w_hi_rs_d  = r_hi_rs;
      w_new_vld  = 1'b0;
      w_new_rs   = 1'b0;
      w_new_data = 1'b0;
      w_new_byte = 8'h00;
      if (w_stb && !w_rw) begin
         unique case (r_state)
            StInit8: begin
               // 8-bit interface: every strobe is a command, low nibble reads as 0.
               w_new_vld  = 1'b1;
               w_new_rs   = w_rs;
               w_new_byte = {w_dat, 4'h0};
               if (w_dat == 4'h2) w_state_d = StNibHi;
            end
            StNibHi: begin
               w_hi_d    = w_dat;
               w_hi_rs_d = w_rs;
               w_state_d = StNibLo;
            end
            StNibLo: begin
               w_new_vld  = 1'b1;
               w_new_rs   = r_hi_rs;
               w_new_data = r_hi_rs;
               w_new_byte = {r_hi, w_dat};
               w_state_d  = StNibHi;
               // Function set with DL=1 drops back to the 8-bit interface.
               if (!r_hi_rs && cmd_lead({r_hi, w_dat}) == CMD_FUNCSET && r_hi[0]) begin
                  w_state_d = StInit8;
               end
            end
            default: w_state_d = StInit8;
         endcase
      end
   end

   // Fill sequencer, pending slot and command/data execution.
   always_comb begin
      w_byte_valid_d = w_new_vld;
      w_byte_out_d   = w_new_vld ? w_new_byte : r_byte_out;
      w_byte_rs_d    = w_new_vld ? w_new_rs : r_byte_rs;
      w_pend_vld_d   = r_pend_vld;
      w_pend_data_d  = r_pend_data;
      w_pend_byte_d  = r_pend_byte;
      w_busy_d       = r_busy;
      w_clr_cnt_d    = r_clr_cnt;
      w_cursor_d     = r_cursor;
      w_id_d         = r_id;
      w_disp_on_d    = r_disp_on;
      w_cg_d         = r_cg;
      w_overrun_d    = r_overrun;
      w_bad_addr_d   = r_bad_addr;
      w_ex_vld       = 1'b0;
      w_ex_data      = 1'b0;
      w_ex_byte      = 8'h00;
      w_mem_we       = 1'b0;
      w_mem_addr     = r_cursor;
      w_mem_wdata    = w_ex_byte;

      if (r_busy) begin
         w_mem_we    = 1'b1;
         w_mem_addr  = r_clr_cnt;
         w_mem_wdata = CLR_CHAR;
         w_clr_cnt_d = r_clr_cnt + 5'd1;
         if (r_clr_cnt == LAST_IDX) begin
            w_busy_d   = 1'b0;
            w_cursor_d = 5'd0;
            w_id_d     = 1'b1;
         end
         if (w_new_vld) begin
            if (!r_pend_vld) begin
               w_pend_vld_d  = 1'b1;
               w_pend_data_d = w_new_data;
               w_pend_byte_d = w_new_byte;
            end else begin
               w_overrun_d = 1'b1;
            end
         end
      end else if (r_pend_vld) begin
         // Pending byte goes first; a byte arriving now takes its place in the slot.
         w_ex_vld      = 1'b1;
         w_ex_data     = r_pend_data;
         w_ex_byte     = r_pend_byte;
         w_pend_vld_d  = w_new_vld;
         w_pend_data_d = w_new_data;
         w_pend_byte_d = w_new_byte;
      end else if (w_new_vld) begin
         w_ex_vld  = 1'b1;
         w_ex_data = w_new_data;
         w_ex_byte = w_new_byte;
      end

      if (w_ex_vld) begin
         if (w_ex_data) begin
            if (!r_cg) begin
               w_mem_we    = 1'b1;
               w_mem_addr  = r_cursor;
               w_mem_wdata = w_ex_byte;
               w_cursor_d  = r_id ? r_cursor + 5'd1 : r_cursor - 5'd1;
            end
         end else begin
            unique case (cmd_lead(w_ex_byte))
               CMD_DDRAM: begin
                  w_cg_d = 1'b0;
                  if (w_ex_byte[6:4] == LINE0_BASE[6:4]) begin
                     w_cursor_d = {1'b0, w_ex_byte[3:0]};
                  end else if (w_ex_byte[6:4] == LINE1_BASE[6:4]) begin
                     w_cursor_d = {1'b1, w_ex_byte[3:0]};
                  end else begin
                     w_bad_addr_d = 1'b1;
                  end
               end
               CMD_CGRAM:   w_cg_d      = 1'b1;
               CMD_DISPCTL: w_disp_on_d = w_ex_byte[2];
               CMD_ENTRY:   w_id_d      = w_ex_byte[1];
               CMD_HOME:    w_cursor_d  = 5'd0;
               CMD_CLEAR: begin
                  w_busy_d    = 1'b1;
                  w_clr_cnt_d = 5'd0;
               end
               // Shift and function set leave the shadow untouched.
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge CCLK) begin
      if (!RSTN) begin
         r_state      <= StInit8;
         r_hi         <= 4'h0;
         r_hi_rs      <= 1'b0;
         r_byte_valid <= 1'b0;
         r_byte_out   <= 8'h00;
         r_byte_rs    <= 1'b0;
         r_pend_vld   <= 1'b0;
         r_pend_data  <= 1'b0;
         r_pend_byte  <= 8'h00;
         r_busy       <= 1'b1;
         r_clr_cnt    <= 5'd0;
         r_cursor     <= 5'd0;
         r_id         <= 1'b1;
         r_disp_on    <= 1'b0;
         r_cg         <= 1'b0;
         r_overrun    <= 1'b0;
         r_bad_addr   <= 1'b0;
      end else begin
         r_state      <= w_state_d;
         r_hi         <= w_hi_d;
         r_hi_rs      <= w_hi_rs_d;
         r_byte_valid <= w_byte_valid_d;
         r_byte_out   <= w_byte_out_d;
         r_byte_rs    <= w_byte_rs_d;
         r_pend_vld   <= w_pend_vld_d;
         r_pend_data  <= w_pend_data_d;
         r_pend_byte  <= w_pend_byte_d;
         r_busy       <= w_busy_d;
         r_clr_cnt    <= w_clr_cnt_d;
         r_cursor     <= w_cursor_d;
         r_id         <= w_id_d;
         r_disp_on    <= w_disp_on_d;
         r_cg         <= w_cg_d;
         r_overrun    <= w_overrun_d;
         r_bad_addr   <= w_bad_addr_d;
      end
   end

   always_ff @(posedge CCLK) begin
      if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
   end

   always_ff @(posedge CCLK) begin
      if (!RSTN) r_rd_char <= 8'h00;
      else       r_rd_char <= r_mem[rd_addr];
   end

`ifdef LCD_RX_STATS_EN
   logic        w_cmd_inc, w_data_inc;
   logic [15:0] r_cmd_cnt, r_data_cnt;

   assign w_cmd_inc  = w_ex_vld & ~w_ex_data;
   assign w_data_inc = w_ex_vld & w_ex_data & ~r_cg;

   always_ff @(posedge CCLK) begin
      if (!RSTN) begin
         r_cmd_cnt  <= 16'h0000;
         r_data_cnt <= 16'h0000;
      end else begin
         if (w_cmd_inc && r_cmd_cnt != 16'hFFFF)   r_cmd_cnt  <= r_cmd_cnt + 16'd1;
         if (w_data_inc && r_data_cnt != 16'hFFFF) r_data_cnt <= r_data_cnt + 16'd1;
      end
   end

   assign cmd_count  = r_cmd_cnt;
   assign data_count = r_data_cnt;
`else
   assign cmd_count  = 16'h0000;
   assign data_count = 16'h0000;
`endif

   assign rd_char    = r_rd_char;
   assign byte_valid = r_byte_valid;
   assign byte_out   = r_byte_out;
   assign byte_rs    = r_byte_rs;
   assign cursor     = r_cursor;
   assign disp_on    = r_disp_on;
   assign mode4      = (r_state != StInit8);
   assign busy       = r_busy;
   assign overrun    = r_overrun;
   assign bad_addr   = r_bad_addr;

endmodule
